// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative RV32M multiply unit (MUL, MULH, MULHSU, MULHU).
//
// The operands are converted to unsigned magnitudes and latched on the accept edge.
// Over 32 CALC cycles, each set multiplier bit adds the shifted multiplicand to a
// 64-bit accumulator. The shifted multiplicand comes from shift_expander.
// One FIXUP cycle then applies the sign and selects the requested product word.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of any in-flight operation
//   in_valid   op/rs1/rs2 are valid
//   in_ready   unit can accept an operation (IDLE only)
//   op         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1        multiplicand (a)
//   rs2        multiplier (b)
//   out_valid  result is valid (DONE only)
//   out_ready  consumer takes the result
//   result     selected 32-bit product word

// shift_expander: zero-extends a 32-bit value to 64 bits and shifts it left.
//   input_a      32-bit value
//   shift_index  left shift amount, 0..63
//   output_b     64-bit shifted value
module shift_expander (
  input  logic [31:0] input_a,
  input  logic [5:0]  shift_index,
  output logic [63:0] output_b
);

  assign output_b = {32'h0, input_a} << shift_index;

endmodule

module shift_add_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [1:0]        op_q;
  logic              sign_q;
  logic [2*XLEN-1:0] acc;
  logic [4:0]        counter;

  logic              accept;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [2*XLEN-1:0] shifted_a;
  logic [2*XLEN-1:0] signed_p;

  shift_expander u_shift_expander (
    .input_a     (mag_a),
    .shift_index ({1'b0, counter}),
    .output_b    (shifted_a)
  );

  // Only the signed operand kinds contribute a sign.
  // A magnitude of 0x80000000 is still correct when read as unsigned.
  assign neg_a = rs1[XLEN-1] && (op == OP_MULH || op == OP_MULHSU);
  assign neg_b = rs2[XLEN-1] && (op == OP_MULH);
  assign abs_a = neg_a ? (~rs1 + 1'b1) : rs1;
  assign abs_b = neg_b ? (~rs2 + 1'b1) : rs2;

  assign signed_p = sign_q ? (~acc + 1'b1) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept     = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        if (counter == 5'd31) next_state = FIXUP;
      end
      FIXUP: begin
        next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Flush overrides every transition, including a handshake in DONE.
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a   <= '0;
      mag_b   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      acc     <= '0;
      counter <= '0;
      result  <= '0;
    end else if (accept) begin
      mag_a   <= abs_a;
      mag_b   <= abs_b;
      op_q    <= op;
      sign_q  <= neg_a ^ neg_b;
      acc     <= '0;
      counter <= '0;
    end else if (!flush) begin
      if (state == CALC) begin
        if (mag_b[counter]) acc <= acc + shifted_a;
        counter <= counter + 5'd1;
      end else if (state == FIXUP) begin
        result <= (op_q == OP_MUL) ? signed_p[XLEN-1:0] : signed_p[2*XLEN-1:XLEN];
      end
    end
  end

endmodule
